// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder with 4x up/down position counter, illegal-transition flag and min/max flags.
// Optional glitch filter compiled in with QUAD_GLITCH_FILTER_EN.
module quadrature_decoder #(
  parameter int unsigned N    = 16,
  parameter int unsigned FILT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         quad_a,
  input  logic         quad_b,
  input  logic         en,
  input  logic         syn_clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         err_clr,
  output logic [N-1:0] pos,
  output logic         dir,
  output logic         step,
  output logic         err,
  output logic         max_flag,
  output logic         min_flag
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Init counter is sized for the longest (filtered) fill so both builds share one width
  localparam int unsigned INIT_W = $clog2(FILT + 3);
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int unsigned INIT_LEN = 2 + FILT;
`else
  localparam int unsigned INIT_LEN = 2;
`endif

  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] ab_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {quad_a, quad_b};
      sync2_q <= sync1_q;
    end
  end

`ifdef QUAD_GLITCH_FILTER_EN
  localparam int unsigned FCNT_W = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]        filt_q;
  logic [1:0]        filt_d;
  logic [FCNT_W-1:0] fcnt_q;
  logic [FCNT_W-1:0] fcnt_d;

  // Accept a new phase pair only after it has differed for FILT consecutive edges
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FCNT_W'(FILT - 1)) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 2'b00;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign ab_c = filt_q;
`else
  assign ab_c = sync2_q;
`endif

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic [INIT_W-1:0] init_cnt_q;
  logic [INIT_W-1:0] init_cnt_d;
  logic [1:0]        prev_q;
  logic [1:0]        prev_d;
  logic [N-1:0]      pos_q;
  logic [N-1:0]      pos_d;
  logic              dir_q;
  logic              dir_d;
  logic              step_q;
  logic              step_d;
  logic              err_q;
  logic              err_d;

  logic up_c;
  logic dn_c;
  logic ill_c;

  // Gray decode of prev -> cur: up is 00->01->11->10->00, two-bit change is illegal
  always_comb begin
    up_c  = 1'b0;
    dn_c  = 1'b0;
    ill_c = 1'b0;
    case ({prev_q, ab_c})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up_c  = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dn_c  = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: ill_c = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = prev_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    err_d      = err_clr ? 1'b0 : err_q;
    pos_d      = pos_q;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_W'(INIT_LEN)) begin
          prev_d  = ab_c;
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      ST_RUN: begin
        prev_d = ab_c;
        if (up_c || dn_c) begin
          step_d = 1'b1;
          dir_d  = up_c;
        end
        if (ill_c) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Clear beats load beats count; step/dir still report when overridden
    if (syn_clr) begin
      pos_d = '0;
    end else if (load) begin
      pos_d = d;
    end else if (en && step_d) begin
      pos_d = dir_d ? pos_q + N'(1) : pos_q - N'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_q     <= 2'b00;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      err_q      <= err_d;
    end
  end

  assign pos      = pos_q;
  assign dir      = dir_q;
  assign step     = step_q;
  assign err      = err_q;
  assign max_flag = &pos_q;
  assign min_flag = ~|pos_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomized bench for quadrature_decoder against a transaction-level position model.
module tb_quadrature_decoder;

  localparam int unsigned N    = 16;
  localparam int unsigned FILT = 4;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int LAT = 2 + FILT;
`else
  localparam int LAT = 2;
`endif

  logic         clk;
  logic         reset_n;
  logic         quad_a;
  logic         quad_b;
  logic         en;
  logic         syn_clr;
  logic         load;
  logic [N-1:0] d;
  logic         err_clr;
  logic [N-1:0] pos;
  logic         dir;
  logic         step;
  logic         err;
  logic         max_flag;
  logic         min_flag;

  quadrature_decoder #(.N(N), .FILT(FILT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .en       (en),
    .syn_clr  (syn_clr),
    .load     (load),
    .d        (d),
    .err_clr  (err_clr),
    .pos      (pos),
    .dir      (dir),
    .step     (step),
    .err      (err),
    .max_flag (max_flag),
    .min_flag (min_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Step pulse monitor
  int   pulses    = 0;
  int   step_hi   = 0;
  logic step_prev = 1'b0;
  always @(negedge clk) begin
    if (step === 1'b1) step_hi = step_hi + 1;
    if (step === 1'b1 && step_prev !== 1'b1) pulses = pulses + 1;
    step_prev = step;
  end

  // Reference model state
  logic [N-1:0] exp_pos;
  logic         exp_dir;
  logic         exp_err;
  int           exp_pulses;
  logic [1:0]   cur_ab;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Position of a phase pair along the forward Gray cycle
  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] next_ab(input logic [1:0] ab, input int off);
    case ((gidx(ab) + off) & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Drive a new phase pair and advance the model by one decoded transition
  task automatic apply(input logic [1:0] ab);
    int delta;
    delta  = (gidx(ab) - gidx(cur_ab)) & 3;
    quad_a = ab[1];
    quad_b = ab[0];
    cur_ab = ab;
    if (delta == 1 || delta == 3) begin
      exp_pulses++;
      exp_dir = (delta == 1);
      if (en) exp_pos = (delta == 1) ? exp_pos + N'(1) : exp_pos - N'(1);
    end else if (delta == 2) begin
      exp_err = 1'b1;
    end
  endtask

  task automatic move(input logic [1:0] ab, input bit lat_chk);
    logic [N-1:0] old_pos;
    logic [1:0]   old_ab;
    old_pos = exp_pos;
    old_ab  = cur_ab;
    apply(ab);
    if (lat_chk) begin
      tick(LAT);
      check("lat_pos_before", 32'(pos), 32'(old_pos));
      check("lat_step_before", 32'(step), 32'(0));
      tick(1);
      check("lat_pos_after", 32'(pos), 32'(exp_pos));
      check("lat_step_after", 32'(step), 32'((((gidx(ab) - gidx(old_ab)) & 3) % 2) == 1));
      tick(1);
      check("lat_step_width", 32'(step), 32'(0));
    end else begin
      tick(LAT + 2);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pos"}, 32'(pos), 32'(exp_pos));
    check({tag, "_dir"}, 32'(dir), 32'(exp_dir));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_max"}, 32'(max_flag), 32'(exp_pos == '1));
    check({tag, "_min"}, 32'(min_flag), 32'(exp_pos == '0));
  endtask

  task automatic do_load(input logic [N-1:0] v);
    load = 1'b1;
    d    = v;
    tick(1);
    load    = 1'b0;
    exp_pos = v;
    check("load_pos", 32'(pos), 32'(exp_pos));
  endtask

  initial begin
    reset_n = 1'b0;
    quad_a  = 1'b1;
    quad_b  = 1'b1;
    cur_ab  = 2'b11;
    en      = 1'b1;
    syn_clr = 1'b0;
    load    = 1'b0;
    d       = '0;
    err_clr = 1'b0;
    exp_pos = '0;
    exp_dir = 1'b0;
    exp_err = 1'b0;
    exp_pulses = 0;

    tick(2);
    check_state("reset");
    check("reset_step", 32'(step), 32'(0));

    // Inputs parked at 11 through INIT must not look like a transition
    reset_n = 1'b1;
    tick(LAT + 20);
    check_state("init");
    check("init_pulses", 32'(pulses), 32'(0));

    for (int i = 0; i < 8; i++) begin
      move(next_ab(cur_ab, 1), i == 0);
      tick(6);
    end
    check_state("fwd8");
    check("fwd8_pos", 32'(pos), 32'(8));
    check("fwd8_pulses", 32'(pulses), 32'(exp_pulses));
    check("fwd8_width", 32'(step_hi), 32'(exp_pulses));

    // Wrap below zero and above max
    do_load(N'(1));
    for (int i = 0; i < 3; i++) begin
      move(next_ab(cur_ab, 3), 1'b0);
      check_state("rev_wrap");
    end
    check("rev_wrap_val", 32'(pos), 32'(16'hFFFE));
    do_load(N'(16'hFFFE));
    for (int i = 0; i < 2; i++) begin
      move(next_ab(cur_ab, 1), 1'b0);
      check_state("fwd_wrap");
    end
    check("fwd_wrap_val", 32'(pos), 32'(0));

    // Illegal jump, then err_clr racing a second illegal jump, then err_clr alone
    move(next_ab(cur_ab, 2), 1'b0);
    check_state("illegal");
    err_clr = 1'b1;
    apply(next_ab(cur_ab, 2));
    tick(LAT + 1);
    err_clr = 1'b0;
    tick(1);
    check_state("err_set_wins");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check_state("err_clr");

    // Counting disabled: pos holds, steps still reported
    move(next_ab(cur_ab, 3), 1'b0);
    check_state("pre_en0");
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      move(next_ab(cur_ab, 1), 1'b0);
      tick(4);
    end
    check_state("en0");
    check("en0_pulses", 32'(pulses), 32'(exp_pulses));
    en = 1'b1;

    // Clear and load coincident with a decoded step
    do_load(N'(7));
    apply(next_ab(cur_ab, 1));
    tick(LAT);
    syn_clr = 1'b1;
    tick(1);
    syn_clr = 1'b0;
    exp_pos = '0;
    check("clr_coinc_step", 32'(step), 32'(1));
    check_state("clr_coinc");
    tick(2);
    apply(next_ab(cur_ab, 3));
    tick(LAT);
    load = 1'b1;
    d    = N'(16'h1234);
    tick(1);
    load    = 1'b0;
    exp_pos = N'(16'h1234);
    check("load_coinc_step", 32'(step), 32'(1));
    check_state("load_coinc");
    tick(2);

`ifdef QUAD_GLITCH_FILTER_EN
    quad_a = ~cur_ab[1];
    tick(3);
    quad_a = cur_ab[1];
    tick(FILT + 8);
    check_state("glitch");
    check("glitch_pulses", 32'(pulses), 32'(exp_pulses));
    move(next_ab(cur_ab, 1), 1'b0);
    tick(2);
    check_state("filt_step");
    check("filt_pulses", 32'(pulses), 32'(exp_pulses));
`endif

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 10))
        0, 1, 2, 3: move(next_ab(cur_ab, 1), 1'b0);
        4, 5:       move(next_ab(cur_ab, 3), 1'b0);
        6:          move(next_ab(cur_ab, 2), 1'b0);
        7: begin
          en = ~en;
          tick(1);
        end
        8: begin
          case ($urandom_range(0, 3))
            0:       do_load('1);
            1:       do_load('0);
            default: do_load(N'($urandom));
          endcase
        end
        9: begin
          if ($urandom_range(0, 1) == 1) begin
            syn_clr = 1'b1;
            tick(1);
            syn_clr = 1'b0;
            exp_pos = '0;
          end else begin
            err_clr = 1'b1;
            tick(1);
            err_clr = 1'b0;
            exp_err = 1'b0;
          end
        end
        default: move(cur_ab, 1'b0);
      endcase
      check_state("rand");
      tick($urandom_range(0, 4));
    end
    tick(4);
    check("rand_pulses", 32'(pulses), 32'(exp_pulses));
    check("rand_width", 32'(step_hi), 32'(exp_pulses));

    // Asynchronous reset mid-operation clears state without a clock edge
    en = 1'b1;
    do_load(N'(16'h00A5));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pos", 32'(pos), 32'(0));
    check("async_rst_min", 32'(min_flag), 32'(1));
    check("async_rst_err", 32'(err), 32'(0));
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
